ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  Receives PS/2 keyboard frames (device-clocked, 11-bit) and turns them into 8-bit scan codes.
//  Codes are buffered in a small FIFO.
//  The FIFO head `dout` feeds the hex 7-segment decoder `din[7:0]`: upper nibble on seg1, lower on seg0.
//  Flow control is a show-ahead pop interface driven by the consumer.
// PARAMETERS
//  FIFO_AW      3      FIFO address width; depth = 2**FIFO_AW entries of 8 bits
//  SYNC_STAGES  2      synchroniser flops on ps2_clk and ps2_data (>=2)
//  TIMEOUT_CYC  50000  clk cycles with no ps2_clk falling edge before a partial frame is discarded
// PORTS
//  clk         in   1  system clock
//  rst         in   1  reset, asynchronous, active-high
//  ps2_clk     in   1  PS/2 clock from device, asynchronous to clk, idles high
//  ps2_data    in   1  PS/2 data from device, asynchronous to clk, idles high
//  rd_en       in   1  pop request; ignored while valid=0
//  clr_err     in   1  synchronous clear of overflow and frame_err
//  dout        out  8  FIFO head scan code; 8'h00 while empty
//  valid       out  1  FIFO non-empty
//  count       out  FIFO_AW+1  number of stored entries
//  overflow    out  1  sticky: a good frame was dropped because the FIFO was full
//  frame_err   out  1  sticky: a frame failed start/parity/stop check
// BEHAVIOUR
//  Reset (async, rst=1):
//   - Outputs: dout=0, valid=0, count=0, overflow=0, frame_err=0.
//   - Internal: bit counter=0, watchdog=0.
//   - Sync flops reset to 1 (idle), so release of reset never produces a false edge.
//   - Reset mid-frame discards the partial frame and all FIFO contents.
//  Sampling:
//   - ps2_clk and ps2_data pass through SYNC_STAGES flops.
//   - Falling edge = registered previous synced clk is 1 and current synced clk is 0.
//   - ps2_data is sampled on that same cycle.
//  Frame layout (bit index 0..10):
//   - 0 = start (must be 0)
//   - 1..8 = data, LSB first
//   - 9 = odd parity over data+parity
//   - 10 = stop (must be 1)
//  Bit counter:
//   - At index 0, a sampled 1 is treated as noise; the counter stays 0 and no error is flagged.
//   - Otherwise the counter increments on each edge.
//   - After index 10 the counter returns to 0.
//  Frame check on the index-10 edge:
//   - Parity odd and stop=1 -> push data; valid/count update on the next clk edge.
//   - Any failure -> discard the frame and set frame_err on the next edge.
//  Latency: valid rises at most SYNC_STAGES+2 clk cycles after the raw 11th ps2_clk fall.
//  Watchdog:
//   - Counts while the bit counter is nonzero; clears on every falling edge.
//   - Reaching TIMEOUT_CYC forces the bit counter to 0 and discards partial data.
//   - A timeout sets no flag.
//  FIFO pointers:
//   - Read and write pointers are FIFO_AW bits and wrap modulo depth.
//   - count distinguishes full from empty.
//   - dout = mem[rptr], combinational from registered state.
//  Pop: rd_en && valid advances rptr on the next edge.
//  Push rules:
//   - Not full: write, wptr++.
//   - Full without pop: frame dropped, overflow set.
//   - Full with simultaneous pop: both occur, count unchanged, overflow not set.
//   - Empty with push and pop: pop ignored, push performed.
//  Errors:
//   - clr_err clears overflow and frame_err next cycle.
//   - A set event in the same cycle as clr_err wins (flag stays 1).
//   - FIFO data is unaffected by error flags.
// TESTING
//  - Frame 0x1C, parity 0, stop 1 -> valid=1, dout=8'h1C, count=1, frame_err=0; rd_en pulse -> valid=0, dout=8'h00.
//  - Frame 0x1C with parity 1 -> count stays 0, frame_err=1; clr_err pulse -> frame_err=0.
//  - Push 9 good frames 0x01..0x09, no pops -> count=8, overflow=1; 8 pops return 0x01..0x08 in order, then valid=0.
//  - With FIFO full, 9th frame's push coincides with rd_en -> count stays 8, overflow=0, last entry = new code.
//  - 5 bits of a frame, then >TIMEOUT_CYC idle, then full frame 0xF0 (parity 1) -> only 0xF0 stored, frame_err=0.
//  - rst pulsed after bit 6 of a frame with 3 codes buffered -> all outputs 0; next frame 0x5A (parity 1) -> dout=8'h5A, count=1.

Source files
------------

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: PS/2 line inputs, consumer pop interface and status outputs
// of the PS/2 receiver FIFO.
//   master : the environment (drives PS/2 lines, rd_en, clr_err)
//   slave  : ps2_rx_fifo (drives dout, valid, count, overflow, frame_err)
interface ps2_rx_fifo_if #(
    parameter int FIFO_AW = 3
);
    logic               ps2_clk;
    logic               ps2_data;
    logic               rd_en;
    logic               clr_err;
    logic [7:0]         dout;
    logic               valid;
    logic [FIFO_AW:0]   count;
    logic               overflow;
    logic               frame_err;

    modport master (
        output ps2_clk, ps2_data, rd_en, clr_err,
        input  dout, valid, count, overflow, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, rd_en, clr_err,
        output dout, valid, count, overflow, frame_err
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: receives 11-bit PS/2 device frames, checks start/parity/stop,
// and buffers the 8-bit scan codes in a show-ahead FIFO.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   bus.slave  ps2_clk/ps2_data (async inputs), rd_en (pop), clr_err,
//              dout (FIFO head, 0 when empty), valid, count,
//              overflow / frame_err (sticky)
module ps2_rx_fifo #(
    parameter int FIFO_AW     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_rx_fifo_if.slave  bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    // ---------------- synchronisers and edge detect ----------------
    // Reset to 1 (idle) so reset release never looks like a falling edge.
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    logic fall, dbit;
    assign fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign dbit = data_sync_q[SYNC_STAGES-1];

    // ---------------- frame deserialiser + watchdog ----------------
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      sh_q, sh_d;
    logic            par_q, par_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            push, bad;

    always_comb begin
        bitcnt_d = bitcnt_q;
        sh_d     = sh_q;
        par_d    = par_q;
        wd_d     = wd_q;
        push     = 1'b0;
        bad      = 1'b0;
        if (fall) begin
            wd_d = '0;
            if (bitcnt_q == 4'd0) begin
                // A high start bit is line noise: stay idle, no error.
                if (!dbit) bitcnt_d = 4'd1;
            end else if (bitcnt_q <= 4'd8) begin
                // LSB arrives first, so shift in from the top.
                sh_d     = {dbit, sh_q[7:1]};
                bitcnt_d = bitcnt_q + 4'd1;
            end else if (bitcnt_q == 4'd9) begin
                par_d    = dbit;
                bitcnt_d = 4'd10;
            end else begin
                bitcnt_d = 4'd0;
                if (dbit && (^{sh_q, par_q})) push = 1'b1;
                else                          bad  = 1'b1;
            end
        end else if (bitcnt_q != 4'd0) begin
            if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                bitcnt_d = 4'd0;
                wd_d     = '0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitcnt_q <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            bitcnt_q <= bitcnt_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            wd_q     <= wd_d;
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               full, pop, wr, drop;

    assign full = (cnt_q == (FIFO_AW+1)'(DEPTH));
    assign pop  = bus.rd_en && (cnt_q != '0);
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign wr   = push && (!full || pop);
    assign drop = push && full && !pop;

    always_comb begin
        cnt_d = cnt_q;
        case ({wr, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= sh_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr)  wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // ---------------- sticky error flags ----------------
    // A set event in the same cycle as clr_err wins.
    logic ovf_q, ovf_d, ferr_q, ferr_d;

    always_comb begin
        ovf_d  = bus.clr_err ? 1'b0 : ovf_q;
        ferr_d = bus.clr_err ? 1'b0 : ferr_q;
        if (drop) ovf_d  = 1'b1;
        if (bad)  ferr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            ferr_q <= ferr_d;
        end
    end

    assign bus.valid     = (cnt_q != '0);
    assign bus.dout      = bus.valid ? mem_q[rptr_q] : 8'h00;
    assign bus.count     = cnt_q;
    assign bus.overflow  = ovf_q;
    assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed PS/2 frames into ps2_rx_fifo. Expected scan codes
// go into a queue when a frame is sent; a monitor compares the FIFO head on
// every accepted pop. Status outputs are checked directly against constants.
module tb_ps2_rx_fifo;
    localparam int AW   = 3;
    localparam int TOUT = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_rx_fifo_if #(.FIFO_AW(AW)) bus ();

    ps2_rx_fifo #(.FIFO_AW(AW), .SYNC_STAGES(2), .TIMEOUT_CYC(TOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected code.
    always @(negedge clk) begin
        if (!rst && bus.rd_en && bus.valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", bus.dout);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.dout !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", bus.dout, e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, clock low 8 cycles, high 4 more.
    // pop_now raises rd_en for exactly the cycle in which the frame push lands.
    task automatic send_bit(input logic b, input logic pop_now);
        bus.ps2_data = b;
        cyc(4);
        bus.ps2_clk = 1'b0;
        if (pop_now) begin
            cyc(2);
            bus.rd_en = 1'b1;
            cyc(1);
            bus.rd_en = 1'b0;
            cyc(5);
        end else begin
            cyc(8);
        end
        bus.ps2_clk = 1'b1;
        cyc(4);
    endtask

    // Send the first nbits of a frame; flip_par corrupts the odd parity bit.
    task automatic send_frame(input logic [7:0] d, input logic flip_par,
                              input int nbits, input logic pop_last);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ flip_par, d, 1'b0};
        for (int i = 0; i < nbits; i++)
            send_bit(f[i], pop_last && (i == 10));
        bus.ps2_data = 1'b1;
    endtask

    task automatic pop1();
        bus.rd_en = 1'b1;
        cyc(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic clr();
        bus.clr_err = 1'b1;
        cyc(1);
        bus.clr_err = 1'b0;
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        bus.rd_en    = 1'b0;
        bus.clr_err  = 1'b0;
        cyc(3);
        check("rst_dout", bus.dout, 8'h00);
        check("rst_valid", bus.valid, 0);
        check("rst_count", bus.count, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_ferr", bus.frame_err, 0);
        rst = 1'b0;
        cyc(5);
        check("idle_valid", bus.valid, 0);

        // Good frame 0x1C (parity 0).
        send_frame(8'h1C, 1'b0, 11, 1'b0); exp_q.push_back(8'h1C);
        check("t1_valid", bus.valid, 1);
        check("t1_dout", bus.dout, 8'h1C);
        check("t1_count", bus.count, 1);
        check("t1_ferr", bus.frame_err, 0);
        pop1();
        check("t1_valid_after", bus.valid, 0);
        check("t1_dout_after", bus.dout, 8'h00);

        // Bad parity.
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        check("t2_count", bus.count, 0);
        check("t2_ferr", bus.frame_err, 1);
        clr();
        check("t2_ferr_clr", bus.frame_err, 0);

        // Nine frames into an 8-deep FIFO: the ninth is dropped.
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b0, 11, 1'b0);
            if (i <= 8) exp_q.push_back(8'(i));
        end
        check("t3_count", bus.count, 8);
        check("t3_ovf", bus.overflow, 1);
        check("t3_head", bus.dout, 8'h01);
        for (int i = 0; i < 8; i++) pop1();
        check("t3_valid_drained", bus.valid, 0);
        clr();
        check("t3_ovf_clr", bus.overflow, 0);

        // Full FIFO, ninth push coincides with a pop.
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h11 + 8'(i), 1'b0, 11, 1'b0);
            exp_q.push_back(8'h11 + 8'(i));
        end
        check("t4_full_count", bus.count, 8);
        send_frame(8'h19, 1'b0, 11, 1'b1); exp_q.push_back(8'h19);
        check("t4_count", bus.count, 8);
        check("t4_ovf", bus.overflow, 0);
        check("t4_head", bus.dout, 8'h12);
        for (int i = 0; i < 8; i++) pop1();
        check("t4_valid_drained", bus.valid, 0);

        // Partial frame, watchdog timeout, then a clean frame.
        send_frame(8'hA5, 1'b0, 5, 1'b0);
        cyc(TOUT + 50);
        send_frame(8'hF0, 1'b0, 11, 1'b0); exp_q.push_back(8'hF0);
        check("t5_count", bus.count, 1);
        check("t5_dout", bus.dout, 8'hF0);
        check("t5_ferr", bus.frame_err, 0);
        pop1();

        // Reset mid-frame with three codes buffered.
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h21 + 8'(i), 1'b0, 11, 1'b0);
            exp_q.push_back(8'h21 + 8'(i));
        end
        check("t6_count3", bus.count, 3);
        send_frame(8'h77, 1'b0, 6, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        #2;
        check("t6_rst_dout", bus.dout, 8'h00);
        check("t6_rst_valid", bus.valid, 0);
        check("t6_rst_count", bus.count, 0);
        check("t6_rst_ovf", bus.overflow, 0);
        check("t6_rst_ferr", bus.frame_err, 0);
        cyc(2);
        rst = 1'b0;
        cyc(4);
        send_frame(8'h5A, 1'b0, 11, 1'b0); exp_q.push_back(8'h5A);
        check("t6_dout", bus.dout, 8'h5A);
        check("t6_count", bus.count, 1);
        check("t6_ferr", bus.frame_err, 0);
        pop1();
        cyc(2);
        check("end_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
